// File: rtl/rca_seq_pkg.sv
// rca_seq_pkg
// Shared types and sizing helpers for the nibble-serial adder.
//   state_t    : controller states (IDLE, RUN, DONE)
//   SLICE_W    : width of the shared ripple-carry slice
//   nib_count  : number of slice passes needed for a given operand width
//   cnt_width  : nibble counter width, never narrower than one bit
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int nib_count(input int width);
    return width / SLICE_W;
  endfunction

  // A single-nibble adder still needs a one-bit counter to stay legal.
  function automatic int cnt_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/rca_nibble_seq_rca.sv
// rca
// Four-bit ripple-carry adder slice, purely combinational.
//   a, b : nibble operands
//   ci   : carry in
//   s    : nibble sum
//   co   : carry out of bit 3
module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic carry;

  // Carry ripples through a local variable so every bit sees the carry of
  // the bit below it within the same evaluation.
  always_comb begin
    carry = ci;
    s     = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/rca_nibble_seq.sv
// rca_nibble_seq
// Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple-carry slice,
// adding one nibble per clock, least significant nibble first.
//   clk, rst              : clock and synchronous active-high reset
//   in_valid/in_ready     : operand handshake (ready only while idle)
//   in_a, in_b, in_cin    : operands and carry in
//   out_valid/out_ready   : result handshake (valid only when done)
//   out_sum               : A+B+cin modulo 2^WIDTH
//   out_cout, out_ovf     : unsigned carry out and signed overflow
//   busy                  : high whenever an operation is in progress or held
module rca_nibble_seq
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int CNT_W = cnt_width(NIB);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("rca_nibble_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [3:0]         slice_s;
  logic               slice_co;

  rca u_slice (
    .a  (a_q[SLICE_W-1:0]),
    .b  (b_q[SLICE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Next-state logic. The handshake flags are derived from the next state so
  // they come straight out of flops and agree with the state every cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          cnt_d   = '0;
          sa_d    = in_a[WIDTH-1];
          sb_d    = in_b[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        // Constant-index writes keep the nibble placement free of variable
        // part-selects that could run past the top for WIDTH=4.
        for (int n = 0; n < NIB; n++) begin
          if (cnt_q == CNT_W'(n)) begin
            sum_d[n*SLICE_W +: SLICE_W] = slice_s;
          end
        end
        carry_d = slice_co;
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NIB - 1)) begin
          state_d = DONE;
          cout_d  = slice_co;
          ovf_d   = (sa_q == sb_q) && (slice_s[3] != sa_q);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // Single register bank for the controller and datapath; reset wins over
  // any handshake and drops an in-flight operation without a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_rca_nibble_seq.sv
// tb_rca_nibble_seq
// Self-checking bench for the nibble-serial adder at WIDTH=16. Expected
// results come from plain integer arithmetic on the operands.
module tb_rca_nibble_seq;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rca_nibble_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it; all driving and sampling
  // happens at that point, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: {ovf, cout, sum} from the true W+1 bit sum and sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  // Runs one full transaction and returns what the DUT produced plus the
  // number of edges from accept to the first out_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output logic [W-1:0] s, output logic c, output logic o,
                       output int lat);
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    if (!in_ready && waitc >= 20) lat = -1;
    s = out_sum;
    c = out_cout;
    o = out_ovf;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({out_sum, out_cout, out_ovf} !== '0) begin bad++; $display("[TB] FAIL reset_outputs got=%h/%b/%b exp=0", out_sum, out_cout, out_ovf); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [6];
    logic [W-1:0] vb [6];
    logic         vc [6];
    logic [W-1:0] s;
    logic         c, o;
    logic [W+1:0] e;
    int           lat;
    va = '{16'h1234, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    vb = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'hFFFF};
    vc = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
    for (int i = 0; i < 6; i++) begin
      e = model(va[i], vb[i], vc[i]);
      do_op(va[i], vb[i], vc[i], s, c, o, lat);
      total++; if (s !== e[W-1:0]) begin bad++; $display("[TB] FAIL dir_sum[%0d] got=%h exp=%h", i, s, e[W-1:0]); end
      total++; if (c !== e[W]) begin bad++; $display("[TB] FAIL dir_cout[%0d] got=%b exp=%b", i, c, e[W]); end
      total++; if (o !== e[W+1]) begin bad++; $display("[TB] FAIL dir_ovf[%0d] got=%b exp=%b", i, o, e[W+1]); end
      total++; if (lat != NIB) begin bad++; $display("[TB] FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, NIB); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic         cin, c, o;
    logic [W+1:0] e;
    int           lat;
    for (int i = 0; i < 16; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      e   = model(a, b, cin);
      do_op(a, b, cin, s, c, o, lat);
      total++; if ({o, c, s} !== e) begin bad++; $display("[TB] FAIL rand[%0d] %h+%h+%b got=%b/%b/%h exp=%b/%b/%h", i, a, b, cin, o, c, s, e[W+1], e[W], e[W-1:0]); end
      total++; if (lat != NIB) begin bad++; $display("[TB] FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, NIB); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, s;
    logic         c, o;
    logic [W+1:0] e;
    int           lat;
    int           waitc;
    a = 16'hA5C3;
    b = 16'h5A4D;
    e = model(a, b, 1'b1);
    in_a = a; in_b = b; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 30) begin
      tick();
      waitc++;
    end
    total++; if (waitc != NIB) begin bad++; $display("[TB] FAIL bp_latency got=%0d exp=%0d", waitc, NIB); end
    for (int k = 0; k < 10; k++) begin
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom); in_valid = 1'b1;
      tick();
      total++; if ({out_valid, out_ovf, out_cout, out_sum} !== {1'b1, e}) begin bad++; $display("[TB] FAIL bp_hold[%0d] got=%b/%b/%b/%h exp=1/%b/%b/%h", k, out_valid, out_ovf, out_cout, out_sum, e[W+1], e[W], e[W-1:0]); end
      total++; if ({in_ready, busy} !== 2'b01) begin bad++; $display("[TB] FAIL bp_flags[%0d] got=%b%b exp=01", k, in_ready, busy); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if ({out_valid, in_ready, busy} !== 3'b010) begin bad++; $display("[TB] FAIL bp_release got=%b%b%b exp=010", out_valid, in_ready, busy); end
    e = model(16'h0F0F, 16'h00F1, 1'b0);
    do_op(16'h0F0F, 16'h00F1, 1'b0, s, c, o, lat);
    total++; if ({o, c, s} !== e) begin bad++; $display("[TB] FAIL bp_next got=%b/%b/%h exp=%b/%b/%h", o, c, s, e[W+1], e[W], e[W-1:0]); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s;
    logic         c, o;
    int           lat;
    int           seen;
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({out_valid, in_ready, busy} !== 3'b010) begin bad++; $display("[TB] FAIL mid_flags got=%b%b%b exp=010", out_valid, in_ready, busy); end
    total++; if (out_sum !== '0) begin bad++; $display("[TB] FAIL mid_sum got=%h exp=0000", out_sum); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL mid_no_result got=%0d exp=0", seen); end
    do_op(16'h00FF, 16'h0001, 1'b0, s, c, o, lat);
    total++; if ({o, c, s} !== {1'b0, 1'b0, 16'h0100}) begin bad++; $display("[TB] FAIL mid_fresh got=%b/%b/%h exp=0/0/0100", o, c, s); end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] q[$];
    logic [W+1:0] e;
    int           acc[3];
    int           n_acc;
    int           n_res;
    bit           accept;
    n_acc = 0;
    n_res = 0;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && n_res < 3; k++) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL b2b_unexpected_result got=%h", out_sum);
        end else begin
          e = q.pop_front();
          total++; if ({out_ovf, out_cout, out_sum} !== e) begin bad++; $display("[TB] FAIL b2b_result[%0d] got=%b/%b/%h exp=%b/%b/%h", n_res, out_ovf, out_cout, out_sum, e[W+1], e[W], e[W-1:0]); end
        end
        n_res++;
      end
      accept = in_ready && in_valid;
      if (accept) begin
        q.push_back(model(in_a, in_b, in_cin));
        acc[n_acc] = cyc;
        n_acc++;
      end
      tick();
      if (accept) begin
        if (n_acc == 3) in_valid = 1'b0;
        else begin
          in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++; if (n_res != 3) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=3", n_res); end
    if (n_acc == 3) begin
      total++; if (acc[1] - acc[0] != NIB + 2) begin bad++; $display("[TB] FAIL b2b_interval0 got=%0d exp=%0d", acc[1] - acc[0], NIB + 2); end
      total++; if (acc[2] - acc[1] != NIB + 2) begin bad++; $display("[TB] FAIL b2b_interval1 got=%0d exp=%0d", acc[2] - acc[1], NIB + 2); end
    end else begin
      total++; bad++;
      $display("[TB] FAIL b2b_accepts got=%0d exp=3", n_acc);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
